taxi_axil_reg_if: RTL and testbench
===================================

# taxi_axil_reg_if

AXI4-lite slave endpoint that converts AXI4-lite transactions into a simple held-enable register access bus with independent read and write ports. It sits directly downstream of the AXI4-lite register slice and terminates the bus in front of CSR/register-file logic. Reads and writes run through separate, concurrent channel state machines. An optional timeout completes stalled accesses with SLVERR.

## Interface
Parameters:
- TIMEOUT, 16: cycles of asserted enable without ack before SLVERR completion; used only with the macro; must be ≥1 (elaboration error otherwise).
- DATA_W, ADDR_W, STRB_W: not parameters; taken from s_axil_wr.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_wr  taxi_axil_if wr_slv  -  AXI4-lite write slave
- s_axil_rd  taxi_axil_if rd_slv  -  AXI4-lite read slave
- reg_wr_addr  out  ADDR_W  write address, captured awaddr
- reg_wr_data  out  DATA_W  captured wdata
- reg_wr_strb  out  STRB_W  captured wstrb
- reg_wr_en  out  1  write enable, held until acked
- reg_wr_ack  in  1  write complete
- reg_rd_addr  out  ADDR_W  read address, captured araddr
- reg_rd_en  out  1  read enable, held until acked
- reg_rd_data  in  DATA_W  read data, valid with reg_rd_ack
- reg_rd_ack  in  1  read complete

## Operation
- Write FSM states: IDLE, ACCESS, RESP.
  - IDLE: awready and wready are combinational and asserted together only when awvalid && wvalid. Neither is asserted while only one is valid. On the handshake, capture addr/data/strb and go to ACCESS.
  - ACCESS: reg_wr_en=1. On reg_wr_ack, set bresp=OKAY and go to RESP.
  - RESP: bvalid=1 until bready, then IDLE.
- Read FSM, identical structure.
  - IDLE: arready = arvalid.
  - ACCESS: reg_rd_en=1. On reg_rd_ack, capture reg_rd_data into rdata, set rresp=OKAY, go to RESP.
  - RESP: rvalid=1 until rready, then IDLE.
- Read and write FSMs are fully independent; both enables may be high in the same cycle.
- awprot/arprot are ignored. buser/ruser are driven 0.
- An ack outside ACCESS is ignored.
- Address, data and strobe outputs are stable for the whole ACCESS; they may hold stale values in IDLE.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, reg_wr_en, reg_rd_en = 0. bresp, rresp, rdata, reg_wr_addr/data/strb, reg_rd_addr = 0.
- Handshake in cycle N → enable high in cycle N+1. Ack in cycle M ≥ N+1 → enable low and bvalid/rvalid high in cycle M+1.
- Minimum latency: handshake to response valid is 2 cycles. Maximum throughput is one transaction per channel every 3 cycles (ready is only asserted in IDLE).
- bvalid/rvalid, bresp/rresp and rdata are held stable while ready is low.
- Async reset mid-transaction: all outputs drop immediately and the in-flight transaction is discarded. The upstream master must be reset together with this block.

## Configuration
- TAXI_AXIL_REG_IF_TIMEOUT_EN defined:
  - Each channel has a counter of width $clog2(TIMEOUT+1), cleared on entry to ACCESS and incremented each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT without ack, the FSM goes to RESP with resp=SLVERR (2'b10); rdata is 0 for reads. Enable is therefore high for exactly TIMEOUT cycles.
  - Ack in the same cycle the count is reached wins, giving OKAY.
- Not defined: no counter is built; ACCESS waits for ack indefinitely.

## Structure
- The shared package taxi_axil_pkg holds:
  - resp constants AXIL_RESP_OKAY=2'b00 and AXIL_RESP_SLVERR=2'b10;
  - the channel state typedef enum {IDLE, ACCESS, RESP}.
- Sub-module taxi_axil_reg_if_tmo (the timeout counter with clear, enable and expired outputs) is instantiated once per channel, only under the macro.

## Test plan
- Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, ack in the first enable cycle → reg_wr_en high exactly 1 cycle with addr 0x10, data 0xDEADBEEF, strb 0xF. bvalid is asserted 2 cycles after the handshake with bresp=00.
- awvalid asserted 3 cycles before wvalid, wstrb=0x3 → awready/wready stay low until wvalid's first cycle, then pulse together. reg_wr_strb=0x3.
- Read araddr=0x20, ack 4 cycles after enable with data 0x12345678, rready held low 3 cycles → reg_rd_en high 5 cycles. rvalid is stable for 3+1 cycles with rdata=0x12345678 and rresp=00.
- Macro defined, TIMEOUT=16, no ack → enable high exactly 16 cycles, then rresp=10 with rdata=0 (and bresp=10 for writes). Repeating with ack on the 16th cycle → OKAY.
- Simultaneous write to 0x4 and read of 0x8, both acked immediately → both enables high in the same cycle. bvalid and rvalid both assert 2 cycles after the handshake.
- rst_n driven low during write ACCESS → reg_wr_en drops in the same cycle without waiting for clk. After release, a new write to 0x30 completes normally with OKAY.

Source files
------------

// File: rtl/taxi_axil_pkg.sv
// Shared AXI4-lite definitions: response codes and the per-channel state type
// used by the register-interface endpoint.
package taxi_axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } axil_chan_state_t;

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-lite bus bundle with separate write/read master and slave views.
interface taxi_axil_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int BUSER_W = 1,
  parameter int RUSER_W = 1
);

  logic [ADDR_W-1:0]  awaddr;
  logic [2:0]         awprot;
  logic               awvalid;
  logic               awready;
  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic [BUSER_W-1:0] buser;
  logic               bvalid;
  logic               bready;

  logic [ADDR_W-1:0]  araddr;
  logic [2:0]         arprot;
  logic               arvalid;
  logic               arready;
  logic [DATA_W-1:0]  rdata;
  logic [1:0]         rresp;
  logic [RUSER_W-1:0] ruser;
  logic               rvalid;
  logic               rready;

  modport wr_mst (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, buser, bvalid, output bready
  );

  modport wr_slv (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, buser, bvalid, input bready
  );

  modport rd_mst (
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, ruser, rvalid, output rready
  );

  modport rd_slv (
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, ruser, rvalid, input rready
  );

endinterface

// File: rtl/taxi_axil_reg_if_tmo.sv
// Per-channel access timeout counter; only built when TAXI_AXIL_REG_IF_TIMEOUT_EN
// is defined.
`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
module taxi_axil_reg_if_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the TIMEOUT-th un-acked cycle so the enable is high exactly TIMEOUT cycles.
  assign expired = en && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/taxi_axil_reg_if.sv
// AXI4-lite slave to held-enable register bus, with independent read/write FSMs.
// Optional access timeout (SLVERR) enabled by defining TAXI_AXIL_REG_IF_TIMEOUT_EN.
module taxi_axil_reg_if #(
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  taxi_axil_if.wr_slv                 s_axil_wr,
  taxi_axil_if.rd_slv                 s_axil_rd,
  output logic [s_axil_wr.ADDR_W-1:0] reg_wr_addr,
  output logic [s_axil_wr.DATA_W-1:0] reg_wr_data,
  output logic [s_axil_wr.STRB_W-1:0] reg_wr_strb,
  output logic                        reg_wr_en,
  input  logic                        reg_wr_ack,
  output logic [s_axil_wr.ADDR_W-1:0] reg_rd_addr,
  output logic                        reg_rd_en,
  input  logic [s_axil_wr.DATA_W-1:0] reg_rd_data,
  input  logic                        reg_rd_ack
);

  import taxi_axil_pkg::*;

  localparam int DATA_W = s_axil_wr.DATA_W;
  localparam int ADDR_W = s_axil_wr.ADDR_W;
  localparam int STRB_W = s_axil_wr.STRB_W;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("taxi_axil_reg_if: TIMEOUT must be at least 1");
  end

  if (s_axil_rd.DATA_W != DATA_W || s_axil_rd.ADDR_W != ADDR_W) begin : g_bad_width
    $error("taxi_axil_reg_if: read and write interfaces must have matching widths");
  end

  logic unused_prot;
  assign unused_prot = ^{s_axil_wr.awprot, s_axil_rd.arprot};

  axil_chan_state_t  wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_start;
  logic              wr_expired;

  axil_chan_state_t  rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rd_start;
  logic              rd_expired;

`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
  taxi_axil_reg_if_tmo #(
    .TIMEOUT(TIMEOUT)
  ) u_wr_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wr_start),
    .en     (reg_wr_en && !reg_wr_ack),
    .expired(wr_expired)
  );

  taxi_axil_reg_if_tmo #(
    .TIMEOUT(TIMEOUT)
  ) u_rd_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rd_start),
    .en     (reg_rd_en && !reg_rd_ack),
    .expired(rd_expired)
  );
`else
  assign wr_expired = 1'b0;
  assign rd_expired = 1'b0;
`endif

  // Write channel: address and data are accepted only as a pair.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    bresp_d    = bresp_q;
    wr_start   = 1'b0;
    unique case (wr_state_q)
      IDLE: begin
        if (s_axil_wr.awvalid && s_axil_wr.wvalid) begin
          wr_start   = 1'b1;
          wr_addr_d  = s_axil_wr.awaddr;
          wr_data_d  = s_axil_wr.wdata;
          wr_strb_d  = s_axil_wr.wstrb;
          wr_state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (reg_wr_ack) begin
          bresp_d    = AXIL_RESP_OKAY;
          wr_state_d = RESP;
        end else if (wr_expired) begin
          bresp_d    = AXIL_RESP_SLVERR;
          wr_state_d = RESP;
        end
      end
      RESP: begin
        if (s_axil_wr.bready) begin
          wr_state_d = IDLE;
        end
      end
      default: wr_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      bresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read channel: a timed-out read returns zero data rather than stale data.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_start   = 1'b0;
    unique case (rd_state_q)
      IDLE: begin
        if (s_axil_rd.arvalid) begin
          rd_start   = 1'b1;
          rd_addr_d  = s_axil_rd.araddr;
          rd_state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (reg_rd_ack) begin
          rdata_d    = reg_rd_data;
          rresp_d    = AXIL_RESP_OKAY;
          rd_state_d = RESP;
        end else if (rd_expired) begin
          rdata_d    = '0;
          rresp_d    = AXIL_RESP_SLVERR;
          rd_state_d = RESP;
        end
      end
      RESP: begin
        if (s_axil_rd.rready) begin
          rd_state_d = IDLE;
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= IDLE;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axil_wr.awready = wr_start;
  assign s_axil_wr.wready  = wr_start;
  assign s_axil_wr.bvalid  = (wr_state_q == RESP);
  assign s_axil_wr.bresp   = bresp_q;
  assign s_axil_wr.buser   = '0;

  assign s_axil_rd.arready = rd_start;
  assign s_axil_rd.rvalid  = (rd_state_q == RESP);
  assign s_axil_rd.rresp   = rresp_q;
  assign s_axil_rd.rdata   = rdata_q;
  assign s_axil_rd.ruser   = '0;

  assign reg_wr_en   = (wr_state_q == ACCESS);
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_wr_strb = wr_strb_q;

  assign reg_rd_en   = (rd_state_q == ACCESS);
  assign reg_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_taxi_axil_reg_if.sv
// Self-checking bench for taxi_axil_reg_if: directed and randomized transactions
// compared against latency/response rules computed from the transaction parameters.
module tb_taxi_axil_reg_if;

  localparam int TMO = 16;

  typedef struct packed {
    int          early_rdy;
    int          rdy_ok;
    int          en_cyc;
    int          lat;
    int          unstable;
    int          hold_bad;
    int          en_at_resp;
    int          post_valid;
    int          hung;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en, reg_wr_ack, reg_rd_en, reg_rd_ack;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int both_en_cnt = 0;

  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

  taxi_axil_reg_if #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axil_wr  (axil),
    .s_axil_rd  (axil),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_ack (reg_wr_ack),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .reg_rd_ack (reg_rd_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (reg_wr_en && reg_rd_en) both_en_cnt <= both_en_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog expired");
  end

  // Reference rules: ack_dly is the 0-based enable cycle in which ack is given (<0: never).
  function automatic int exp_en_cycles(input int ack_dly);
`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
    if (ack_dly < 0 || ack_dly >= TMO) return TMO;
`endif
    return ack_dly + 1;
  endfunction

  function automatic logic [1:0] exp_resp(input int ack_dly);
`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
    if (ack_dly < 0 || ack_dly >= TMO) return 2'b10;
`endif
    return 2'b00;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lead, input int ack_dly, input int rdy_dly, output obs_t o);
    int k;
    o = '0;
    @(negedge clk);
    axil.awaddr = addr; axil.wdata = data; axil.wstrb = strb; axil.awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      reg_wr_ack = 1'($urandom_range(0, 1));
      #1;
      if (axil.awready || axil.wready) o.early_rdy++;
      @(negedge clk);
    end
    reg_wr_ack = 1'b0;
    axil.wvalid = 1'b1;
    #1;
    o.rdy_ok = (axil.awready && axil.wready) ? 1 : 0;
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin axil.awvalid = 1'b0; axil.wvalid = 1'b0; end
      reg_wr_ack = 1'b0;
      if (axil.bvalid) begin o.en_at_resp = reg_wr_en ? 1 : 0; break; end
      if (reg_wr_en) begin
        if (o.en_cyc == 0) begin
          o.addr = reg_wr_addr; o.data = reg_wr_data; o.strb = reg_wr_strb;
        end else if (reg_wr_addr !== o.addr || reg_wr_data !== o.data || reg_wr_strb !== o.strb) begin
          o.unstable++;
        end
        if (o.en_cyc == ack_dly) reg_wr_ack = 1'b1;
        o.en_cyc++;
      end
    end
    o.hung = (k > 300) ? 1 : 0;
    o.lat  = k;
    o.resp = axil.bresp;
    if (o.hung == 0) begin
      for (int j = 0; j < rdy_dly; j++) begin
        reg_wr_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!axil.bvalid || axil.bresp !== o.resp) o.hold_bad++;
      end
      reg_wr_ack = 1'b0;
      axil.bready = 1'b1;
      @(negedge clk);
      axil.bready = 1'b0;
      o.post_valid = axil.bvalid ? 1 : 0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input int ack_dly, input int rdy_dly, output obs_t o);
    int k;
    o = '0;
    @(negedge clk);
    axil.araddr = addr; axil.arvalid = 1'b1;
    #1;
    o.rdy_ok = axil.arready ? 1 : 0;
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) axil.arvalid = 1'b0;
      reg_rd_ack  = 1'b0;
      reg_rd_data = $urandom;
      if (axil.rvalid) begin o.en_at_resp = reg_rd_en ? 1 : 0; break; end
      if (reg_rd_en) begin
        if (o.en_cyc == 0) o.addr = reg_rd_addr;
        else if (reg_rd_addr !== o.addr) o.unstable++;
        if (o.en_cyc == ack_dly) begin reg_rd_ack = 1'b1; reg_rd_data = data; end
        o.en_cyc++;
      end
    end
    o.hung  = (k > 300) ? 1 : 0;
    o.lat   = k;
    o.resp  = axil.rresp;
    o.rdata = axil.rdata;
    if (o.hung == 0) begin
      for (int j = 0; j < rdy_dly; j++) begin
        reg_rd_ack  = 1'($urandom_range(0, 1));
        reg_rd_data = $urandom;
        @(negedge clk);
        if (!axil.rvalid || axil.rresp !== o.resp || axil.rdata !== o.rdata) o.hold_bad++;
      end
      reg_rd_ack = 1'b0;
      axil.rready = 1'b1;
      @(negedge clk);
      axil.rready = 1'b0;
      o.post_valid = axil.rvalid ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if ({axil.awready, axil.wready, axil.arready} !== 3'b000) $display("FAIL reset_ready: got %b want 000", {axil.awready, axil.wready, axil.arready}); else pass_cnt++;
    chk_cnt++; if ({axil.bvalid, axil.rvalid} !== 2'b00) $display("FAIL reset_valid: got %b want 00", {axil.bvalid, axil.rvalid}); else pass_cnt++;
    chk_cnt++; if ({reg_wr_en, reg_rd_en} !== 2'b00) $display("FAIL reset_en: got %b want 00", {reg_wr_en, reg_rd_en}); else pass_cnt++;
    chk_cnt++; if ({axil.bresp, axil.rresp, axil.rdata} !== 36'h0) $display("FAIL reset_resp: got %h want 0", {axil.bresp, axil.rresp, axil.rdata}); else pass_cnt++;
    chk_cnt++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_addr} !== 100'h0) $display("FAIL reset_regbus: got %h want 0", {reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_addr}); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    obs_t o;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, o);
    chk_cnt++; if (o.hung !== 0 || o.rdy_ok !== 1) $display("FAIL sw_handshake: hung=%0d rdy=%0d want 0/1", o.hung, o.rdy_ok); else pass_cnt++;
    chk_cnt++; if (o.en_cyc !== 1) $display("FAIL sw_en_cycles: got %0d want 1", o.en_cyc); else pass_cnt++;
    chk_cnt++; if ({o.addr, o.data, o.strb} !== {32'h10, 32'hDEADBEEF, 4'hF}) $display("FAIL sw_payload: got %h/%h/%h want 10/deadbeef/f", o.addr, o.data, o.strb); else pass_cnt++;
    chk_cnt++; if (o.lat !== 2) $display("FAIL sw_latency: got %0d want 2", o.lat); else pass_cnt++;
    chk_cnt++; if (o.resp !== 2'b00) $display("FAIL sw_bresp: got %b want 00", o.resp); else pass_cnt++;
    chk_cnt++; if (o.en_at_resp !== 0 || o.post_valid !== 0) $display("FAIL sw_release: en_at_resp=%0d bvalid_after=%0d want 0/0", o.en_at_resp, o.post_valid); else pass_cnt++;
    chk_cnt++; if ({axil.buser, axil.ruser} !== 2'b00) $display("FAIL user_zero: got %b want 00", {axil.buser, axil.ruser}); else pass_cnt++;
  endtask

  task automatic test_aw_before_w();
    obs_t o;
    logic [31:0] d;
    d = $urandom;
    do_write(32'h14, d, 4'h3, 3, 1, 1, o);
    chk_cnt++; if (o.early_rdy !== 0) $display("FAIL awlead_early_ready: got %0d cycles want 0", o.early_rdy); else pass_cnt++;
    chk_cnt++; if (o.rdy_ok !== 1) $display("FAIL awlead_ready_pair: got %0d want 1", o.rdy_ok); else pass_cnt++;
    chk_cnt++; if ({o.addr, o.data, o.strb} !== {32'h14, d, 4'h3}) $display("FAIL awlead_payload: got %h/%h/%h want 14/%h/3", o.addr, o.data, o.strb, d); else pass_cnt++;
    chk_cnt++; if (o.en_cyc !== exp_en_cycles(1) || o.lat !== exp_en_cycles(1) + 1) $display("FAIL awlead_timing: en=%0d lat=%0d want %0d/%0d", o.en_cyc, o.lat, exp_en_cycles(1), exp_en_cycles(1) + 1); else pass_cnt++;
  endtask

  task automatic test_read_stall();
    obs_t o;
    do_read(32'h20, 32'h12345678, 4, 3, o);
    chk_cnt++; if (o.rdy_ok !== 1 || o.hung !== 0) $display("FAIL rd_handshake: rdy=%0d hung=%0d want 1/0", o.rdy_ok, o.hung); else pass_cnt++;
    chk_cnt++; if (o.en_cyc !== 5) $display("FAIL rd_en_cycles: got %0d want 5", o.en_cyc); else pass_cnt++;
    chk_cnt++; if (o.addr !== 32'h20 || o.unstable !== 0) $display("FAIL rd_addr: got %h unstable=%0d want 20/0", o.addr, o.unstable); else pass_cnt++;
    chk_cnt++; if ({o.rdata, o.resp} !== {32'h12345678, 2'b00}) $display("FAIL rd_data_resp: got %h/%b want 12345678/00", o.rdata, o.resp); else pass_cnt++;
    chk_cnt++; if (o.hold_bad !== 0 || o.post_valid !== 0) $display("FAIL rd_hold: bad=%0d rvalid_after=%0d want 0/0", o.hold_bad, o.post_valid); else pass_cnt++;
    chk_cnt++; if (o.lat !== 6 || o.en_at_resp !== 0) $display("FAIL rd_latency: got %0d en=%0d want 6/0", o.lat, o.en_at_resp); else pass_cnt++;
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] a, d;
    logic [3:0] s;
    int ack, rdy, lead, is_wr;
    for (int n = 0; n < 24; n++) begin
      a = $urandom; d = $urandom; s = 4'($urandom);
`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
      ack = $urandom_range(0, TMO + 3);
`else
      ack = $urandom_range(0, 6);
`endif
      rdy = $urandom_range(0, 3); lead = $urandom_range(0, 3); is_wr = $urandom_range(0, 1);
      if (is_wr != 0) begin
        do_write(a, d, s, lead, ack, rdy, o);
        chk_cnt++; if ({o.addr, o.data, o.strb} !== {a, d, s}) $display("FAIL rnd_wr_payload[%0d]: got %h/%h/%h want %h/%h/%h", n, o.addr, o.data, o.strb, a, d, s); else pass_cnt++;
        chk_cnt++; if (o.resp !== exp_resp(ack)) $display("FAIL rnd_wr_resp[%0d]: got %b want %b", n, o.resp, exp_resp(ack)); else pass_cnt++;
      end else begin
        do_read(a, d, ack, rdy, o);
        chk_cnt++; if (o.addr !== a) $display("FAIL rnd_rd_addr[%0d]: got %h want %h", n, o.addr, a); else pass_cnt++;
        chk_cnt++; if ({o.resp, o.rdata} !== {exp_resp(ack), (exp_resp(ack) == 2'b00) ? d : 32'h0}) $display("FAIL rnd_rd_resp[%0d]: got %b/%h want %b/%h", n, o.resp, o.rdata, exp_resp(ack), (exp_resp(ack) == 2'b00) ? d : 32'h0); else pass_cnt++;
      end
      chk_cnt++; if (o.en_cyc !== exp_en_cycles(ack) || o.lat !== exp_en_cycles(ack) + 1) $display("FAIL rnd_timing[%0d]: en=%0d lat=%0d want %0d/%0d", n, o.en_cyc, o.lat, exp_en_cycles(ack), exp_en_cycles(ack) + 1); else pass_cnt++;
      chk_cnt++; if (o.early_rdy + o.unstable + o.hold_bad + o.hung + o.post_valid + o.en_at_resp !== 0 || o.rdy_ok !== 1) $display("FAIL rnd_protocol[%0d]: early=%0d unst=%0d hold=%0d hung=%0d post=%0d en=%0d rdy=%0d", n, o.early_rdy, o.unstable, o.hold_bad, o.hung, o.post_valid, o.en_at_resp, o.rdy_ok); else pass_cnt++;
    end
  endtask

`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    do_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, -1, 0, o);
    chk_cnt++; if (o.en_cyc !== TMO || o.resp !== 2'b10) $display("FAIL tmo_wr: en=%0d resp=%b want %0d/10", o.en_cyc, o.resp, TMO); else pass_cnt++;
    do_read(32'h44, 32'h0BADF00D, -1, 1, o);
    chk_cnt++; if (o.en_cyc !== TMO || {o.resp, o.rdata} !== {2'b10, 32'h0}) $display("FAIL tmo_rd: en=%0d resp=%b data=%h want %0d/10/0", o.en_cyc, o.resp, o.rdata, TMO); else pass_cnt++;
    do_read(32'h48, 32'hCAFEF00D, TMO - 1, 0, o);
    chk_cnt++; if (o.en_cyc !== TMO || {o.resp, o.rdata} !== {2'b00, 32'hCAFEF00D}) $display("FAIL tmo_rd_last_ack: en=%0d resp=%b data=%h want %0d/00/cafef00d", o.en_cyc, o.resp, o.rdata, TMO); else pass_cnt++;
    do_write(32'h4C, 32'h1, 4'h1, 0, TMO - 1, 0, o);
    chk_cnt++; if (o.en_cyc !== TMO || o.resp !== 2'b00) $display("FAIL tmo_wr_last_ack: en=%0d resp=%b want %0d/00", o.en_cyc, o.resp, TMO); else pass_cnt++;
  endtask
`else
  task automatic test_long_stall();
    obs_t o;
    do_read(32'h60, 32'h600DDA7A, 40, 0, o);
    chk_cnt++; if (o.en_cyc !== 41 || {o.resp, o.rdata} !== {2'b00, 32'h600DDA7A}) $display("FAIL stall_rd: en=%0d resp=%b data=%h want 41/00/600dda7a", o.en_cyc, o.resp, o.rdata); else pass_cnt++;
    do_write(32'h64, 32'h2, 4'h2, 0, 40, 0, o);
    chk_cnt++; if (o.en_cyc !== 41 || o.resp !== 2'b00) $display("FAIL stall_wr: en=%0d resp=%b want 41/00", o.en_cyc, o.resp); else pass_cnt++;
  endtask
`endif

  task automatic test_concurrent();
    obs_t ow, orr;
    logic [31:0] wd, rd;
    int base;
    wd = $urandom; rd = $urandom;
    base = both_en_cnt;
    fork
      do_write(32'h4, wd, 4'hF, 0, 0, 0, ow);
      do_read(32'h8, rd, 0, 0, orr);
    join
    chk_cnt++; if (both_en_cnt - base !== 1) $display("FAIL conc_both_en: got %0d cycles want 1", both_en_cnt - base); else pass_cnt++;
    chk_cnt++; if (ow.lat !== 2 || orr.lat !== 2) $display("FAIL conc_latency: wr=%0d rd=%0d want 2/2", ow.lat, orr.lat); else pass_cnt++;
    chk_cnt++; if ({ow.addr, ow.data, ow.resp} !== {32'h4, wd, 2'b00}) $display("FAIL conc_wr: got %h/%h/%b want 4/%h/00", ow.addr, ow.data, ow.resp, wd); else pass_cnt++;
    chk_cnt++; if ({orr.addr, orr.rdata, orr.resp} !== {32'h8, rd, 2'b00}) $display("FAIL conc_rd: got %h/%h/%b want 8/%h/00", orr.addr, orr.rdata, orr.resp, rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    axil.awaddr = 32'h50; axil.wdata = 32'h55; axil.wstrb = 4'hF;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    @(negedge clk);
    chk_cnt++; if (reg_wr_en !== 1'b1) $display("FAIL mid_en_before: got %b want 1", reg_wr_en); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({reg_wr_en, axil.bvalid} !== 2'b00) $display("FAIL mid_async_drop: got %b want 00", {reg_wr_en, axil.bvalid}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({reg_wr_en, axil.bvalid} !== 2'b00) $display("FAIL mid_discarded: got %b want 00", {reg_wr_en, axil.bvalid}); else pass_cnt++;
    do_write(32'h30, 32'h3333, 4'hF, 0, 1, 1, o);
    chk_cnt++; if (o.hung !== 0 || o.resp !== 2'b00 || o.addr !== 32'h30) $display("FAIL mid_recover: hung=%0d resp=%b addr=%h want 0/00/30", o.hung, o.resp, o.addr); else pass_cnt++;
    chk_cnt++; if (o.en_cyc !== 2 || o.lat !== 3) $display("FAIL mid_recover_timing: en=%0d lat=%0d want 2/3", o.en_cyc, o.lat); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    reg_wr_ack = 1'b0; reg_rd_ack = 1'b0; reg_rd_data = '0;
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    test_reset();
    test_single_write();
    test_aw_before_w();
    test_read_stall();
    test_concurrent();
`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
